// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter: shares one 32-bit XOR/compare datapath between four requesters.
// Requests are arbitrated round-robin and the winner's operands go into a two-stage
// pipeline (S1 operand register, S2 output register). Tagged results leave through a
// valid/ready response port that supports backpressure.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          per-requester request, held until granted
//   req_a/req_b  packed operands, requester i uses bits [W*i +: W]
//   gnt          one-hot combinational grant; operands are captured at the closing edge
//   rsp_valid    result valid
//   rsp_ready    consumer accepts the result
//   rsp_id       requester that owns the result
//   rsp_xor      A ^ B
//   rsp_byte_eq  per-byte equality of A and B
//   rsp_eq       full-word equality of A and B
module xor_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*W-1:0]   req_b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [1:0]             rsp_id,
    output logic [W-1:0]           rsp_xor,
    output logic [W/8-1:0]         rsp_byte_eq,
    output logic                   rsp_eq
);

    localparam int unsigned NB = W / 8;

    // S1 operand stage
    logic         s1_v_q;
    logic [W-1:0] s1_a_q;
    logic [W-1:0] s1_b_q;
    logic [1:0]   s1_id_q;
    logic [1:0]   ptr_q;

    // Handshake
    logic s2_adv;
    logic s1_adv;

    // Arbiter
    logic       gnt_any;
    logic [1:0] gnt_idx;
    logic [1:0] cand;

    // Datapath
    logic [W-1:0]  dp_xor;
    logic [NB-1:0] dp_byte_eq;
    logic          dp_eq;

    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !s1_v_q || s2_adv;

    // Round-robin search starting at ptr_q. Grant is forced low during reset so that
    // nothing appears to be accepted while the pipeline is being cleared.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        cand    = '0;
        gnt     = '0;
        if (rst_n && s1_adv) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                cand = ptr_q + off[1:0];
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q  <= 1'b0;
            s1_a_q  <= '0;
            s1_b_q  <= '0;
            s1_id_q <= '0;
            ptr_q   <= '0;
        end else if (s1_adv) begin
            s1_v_q <= gnt_any;
            if (gnt_any) begin
                s1_a_q  <= req_a[32'(gnt_idx) * W +: W];
                s1_b_q  <= req_b[32'(gnt_idx) * W +: W];
                s1_id_q <= gnt_idx;
                ptr_q   <= gnt_idx + 2'd1;
            end
        end
    end

    // A byte matches when its XOR is all zeros.
    always_comb begin
        dp_xor = s1_a_q ^ s1_b_q;
        for (int unsigned k = 0; k < NB; k++) begin
            dp_byte_eq[k] = ~|dp_xor[8*k +: 8];
        end
        dp_eq = &dp_byte_eq;
    end

    // S2 output stage; fields only load with a valid S1 entry so a bubble leaves
    // the previous (don't-care) result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_xor     <= '0;
            rsp_byte_eq <= '0;
            rsp_eq      <= 1'b0;
        end else if (s2_adv) begin
            rsp_valid <= s1_v_q;
            if (s1_v_q) begin
                rsp_id      <= s1_id_q;
                rsp_xor     <= dp_xor;
                rsp_byte_eq <= dp_byte_eq;
                rsp_eq      <= dp_eq;
            end
        end
    end

endmodule
